// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit holding the HI/LO pair.
// Executes mult, multu, div and divu at one bit per cycle on unsigned
// magnitudes, then applies sign correction in a final FIX cycle.
// Ports:
//   clock, reset_n      - rising-edge clock, asynchronous active-low reset
//   start, op[1:0]      - request op (00 mult, 01 multu, 10 div, 11 divu)
//   src_a, src_b        - multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wdata - mthi/mtlo writes, honoured only while idle
//   busy, done          - operation in progress / one-cycle result pulse
//   hi, lo              - registered HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
        return {(2*WIDTH){1'b0}} - v;
    endfunction

    // Magnitude of a two's-complement value; the most-negative value maps
    // to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? negate_w(v) : v;
    endfunction

    state_t            state_r, next_state_s;
    logic              is_div_r, neg_res_r, sign_a_r, div0_r;
    logic [CW-1:0]     count_r;
    logic [WIDTH-1:0]  acc_hi_r, acc_lo_r, oper_r;
    logic              busy_r, done_r;
    logic [WIDTH-1:0]  hi_r, lo_r;

    logic              start_ok_s, op_signed_s;
    logic [WIDTH-1:0]  a_mag_s, b_mag_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH+1:0]  div_diff_s;
    logic [WIDTH-1:0]  step_hi_s, step_lo_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]  res_hi_s, res_lo_s;

    assign start_ok_s  = (state_r == ST_IDLE) && start;
    assign op_signed_s = ~op[0];
    assign a_mag_s     = magnitude(src_a, op_signed_s);
    assign b_mag_s     = magnitude(src_b, op_signed_s);

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum_s  = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, oper_r} : {(WIDTH+1){1'b0}});
    // Divide: trial subtract of the divisor from the shifted remainder;
    // the extra top bit acts as the borrow flag.
    assign div_diff_s = {1'b0, acc_hi_r, acc_lo_r[WIDTH-1]} - {2'b00, oper_r};

    // One iteration step of the shared accumulator pair.
    always_comb begin
        step_hi_s = acc_hi_r;
        step_lo_s = acc_lo_r;
        if (is_div_r) begin
            if (!div_diff_s[WIDTH+1]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
                step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result; divide-by-zero forces the
    // quotient to all ones while the remainder restores the original dividend.
    always_comb begin
        prod_fix_s = neg_res_r ? negate_2w({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
        res_hi_s   = prod_fix_s[2*WIDTH-1:WIDTH];
        res_lo_s   = prod_fix_s[WIDTH-1:0];
        if (is_div_r) begin
            res_hi_s = sign_a_r ? negate_w(acc_hi_r) : acc_hi_r;
            if (div0_r) begin
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = neg_res_r ? negate_w(acc_lo_r) : acc_lo_r;
            end
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Next-state logic of the IDLE/CALC/FIX sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_CALC;
                else       next_state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (count_r == CNT_ZERO) next_state_s = ST_FIX;
                else                     next_state_s = ST_CALC;
            end
            ST_FIX:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= next_state_s;
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            sign_a_r  <= 1'b0;
            div0_r    <= 1'b0;
            count_r   <= CNT_ZERO;
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            oper_r    <= {WIDTH{1'b0}};
        end else if (start_ok_s) begin
            is_div_r  <= op[1];
            neg_res_r <= op_signed_s & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            sign_a_r  <= op_signed_s & src_a[WIDTH-1];
            div0_r    <= op[1] & (src_b == {WIDTH{1'b0}});
            count_r   <= CNT_LAST;
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= op[1] ? a_mag_s : b_mag_s;
            oper_r    <= op[1] ? b_mag_s : a_mag_s;
        end else if (state_r == ST_CALC) begin
            acc_hi_r  <= step_hi_s;
            acc_lo_r  <= step_lo_s;
            if (count_r != CNT_ZERO) count_r <= count_r - CNT_ONE;
            else                     count_r <= count_r;
        end else begin
            acc_hi_r  <= acc_hi_r;
            acc_lo_r  <= acc_lo_r;
        end
    end

    // Registered outputs: busy/done flags and the architectural HI/LO pair.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (state_r == ST_FIX);
            if (state_r == ST_FIX) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end else if (state_r == ST_IDLE) begin
                if (hi_we) hi_r <= wdata;
                else       hi_r <= hi_r;
                if (lo_we) lo_r <= wdata;
                else       lo_r <= lo_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
